// File: rtl/ldl_crc32_fcs_append.sv
// Transmit-side FCS inserter: registers each frame beat and appends the 4-byte CRC-32 FCS
// after the last data byte, either in the eof beat or in one extra tail beat.
//
// state | meaning
// PASS  | forwarding input beats; an eof beat with >= 4 spare bytes closes the frame here
// TAIL  | FCS bytes that did not fit in the eof beat are waiting in the tail register
module ldl_crc32_fcs_append #(
  parameter int NUM = 4,
  parameter int BW  = $clog2(NUM)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [8*NUM-1:0] s_data,
  input  logic [BW-1:0]    s_bnum,
  input  logic             s_eof,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [8*NUM-1:0] m_data,
  output logic [BW-1:0]    m_bnum,
  output logic             m_eof,
  output logic             m_valid,
  input  logic             m_ready
);

  typedef enum logic {
    ST_PASS = 1'b0,
    ST_TAIL = 1'b1
  } state_t;

  state_t             r_state;
  logic [31:0]        r_crc;
  logic [8*NUM-1:0]   r_m_data;
  logic [BW-1:0]      r_m_bnum;
  logic               r_m_eof;
  logic               r_m_valid;
  logic [8*NUM-1:0]   r_tail_data;
  logic [BW-1:0]      r_tail_bnum;

  logic               w_load;
  logic               w_accept;
  int                 w_v;
  int                 w_room;
  logic [BW-1:0]      w_core_bnum;
  logic [31:0]        w_crc_out;
  logic [31:0]        w_fcs;
  logic [8*NUM-1:0]   w_beat;
  logic [8*NUM-1:0]   w_tail;
  logic [BW-1:0]      w_beat_bnum;
  logic [BW-1:0]      w_tail_bnum;

  // Reflected CRC-32 (poly EDB88320) over the first bn bytes of d, byte 0 first; bn=0 means all NUM.
  function automatic logic [31:0] f_crc32_dn(input logic [8*NUM-1:0] d,
                                             input logic [BW-1:0]    bn,
                                             input logic [31:0]      c);
    logic [31:0] x;
    x = c;
    for (int i = 0; i < NUM; i++) begin
      if (bn == '0 || i < int'(bn)) begin
        x = x ^ {24'h0, d[8*(NUM-1-i) +: 8]};
        for (int b = 0; b < 8; b++) begin
          x = x[0] ? ((x >> 1) ^ 32'hEDB8_8320) : (x >> 1);
        end
      end
    end
    return x;
  endfunction

  assign w_load   = !r_m_valid || m_ready;
  assign s_ready  = rst_n && (r_state == ST_PASS) && w_load;
  assign w_accept = s_valid && s_ready;

  assign m_data   = r_m_data;
  assign m_bnum   = r_m_bnum;
  assign m_eof    = r_m_eof;
  assign m_valid  = r_m_valid;

  always_comb begin
    w_v         = (s_bnum == '0) ? NUM : int'(s_bnum);
    w_room      = NUM - w_v;
    w_core_bnum = s_eof ? s_bnum : '0;
    w_crc_out   = f_crc32_dn(s_data, w_core_bnum, r_crc);
    w_fcs       = ~w_crc_out;
    w_beat      = '0;
    w_tail      = '0;
    // Output beat is data bytes, then as many FCS bytes as fit; leftovers go left-aligned to the tail.
    for (int i = 0; i < NUM; i++) begin
      if (!s_eof || i < w_v) begin
        w_beat[8*(NUM-1-i) +: 8] = s_data[8*(NUM-1-i) +: 8];
      end else if (i - w_v < 4) begin
        w_beat[8*(NUM-1-i) +: 8] = w_fcs[8*(3-(i-w_v)) +: 8];
      end
      if (w_room < 4 && i < 4 - w_room) begin
        w_tail[8*(NUM-1-i) +: 8] = w_fcs[8*(3-(w_room+i)) +: 8];
      end
    end
    w_beat_bnum = BW'((w_v + 4) % NUM);
    w_tail_bnum = BW'((4 - w_room) % NUM);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_PASS;
      r_crc       <= '1;
      r_m_data    <= '0;
      r_m_bnum    <= '0;
      r_m_eof     <= 1'b0;
      r_m_valid   <= 1'b0;
      r_tail_data <= '0;
      r_tail_bnum <= '0;
    end else begin
      case (r_state)
        ST_PASS: begin
          if (w_load) begin
            if (w_accept) begin
              r_m_valid <= 1'b1;
              r_m_data  <= w_beat;
              if (!s_eof) begin
                r_m_eof  <= 1'b0;
                r_m_bnum <= '0;
                r_crc    <= w_crc_out;
              end else begin
                r_crc <= '1;
                if (w_room >= 4) begin
                  r_m_eof  <= 1'b1;
                  r_m_bnum <= w_beat_bnum;
                end else begin
                  r_m_eof     <= 1'b0;
                  r_m_bnum    <= '0;
                  r_tail_data <= w_tail;
                  r_tail_bnum <= w_tail_bnum;
                  r_state     <= ST_TAIL;
                end
              end
            end else begin
              r_m_valid <= 1'b0;
            end
          end
        end
        ST_TAIL: begin
          if (w_load) begin
            r_m_valid <= 1'b1;
            r_m_data  <= r_tail_data;
            r_m_bnum  <= r_tail_bnum;
            r_m_eof   <= 1'b1;
            r_state   <= ST_PASS;
          end
        end
        default: r_state <= ST_PASS;
      endcase
    end
  end

endmodule
